pattern_gen: RTL and testbench
==============================

# pattern_gen

- Serial pattern transmitter. On a start request it emits a fixed bit pattern (default `101`, MSB first) a programmable number of times, one bit per clock, on a single-bit line.
- It is the stimulus end of the serial sequence-detector interface in the FSM library. Its `signal` output drives a detector's `signal` input directly.
- It supports optional zero-bit gaps between patterns and an overlapping mode that shares the pattern's longest proper prefix/suffix.
- `pat_end` marks where a downstream detector must fire, for scoreboarding.

## Interface

Clocking and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `PAT_W`, default 3: pattern length in bits (≥2).
- `PAT`, default 3'b101: pattern value, transmitted MSB first.
- `CNT_W`, default 8: width of the repetition count.
- `GAP_W`, default 4: width of the gap length.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `reps`, input, CNT_W: number of pattern instances. Latched on start.
- `gap`, input, GAP_W: zero bits inserted between patterns. Latched on start.
- `overlap`, input, 1: 1 means consecutive patterns share OVL bits. Latched on start; applied only when the latched gap is 0.
- `signal`, output, 1: serial data. Low when not transmitting.
- `sig_valid`, output, 1: high on every transmitted bit, pattern bits and gap bits alike.
- `pat_end`, output, 1: high on the cycle carrying the last bit of each pattern instance.
- `busy`, output, 1: high in SEND and GAP.
- `done`, output, 1: one-cycle pulse after the last bit.

## Operation

- OVL is an elaboration constant: the length of the longest proper prefix of PAT equal to a suffix. For `101`, OVL = 1.
- State machine states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 with reps≠0 latches reps/gap/overlap, loads remaining = reps and bit index = PAT_W−1, then goes to SEND.
  - start=1 with reps=0 goes to DONE; no bits are sent.
- SEND:
  - `signal` = PAT[idx], `sig_valid` = 1.
  - idx decrements each cycle.
  - On idx = 0, `pat_end` = 1 and remaining decrements.
  - If remaining becomes 0, go to DONE.
  - Else if gap ≠ 0, go to GAP with gap counter = gap.
  - Else stay in SEND. idx reloads to PAT_W−1−OVL if overlap=1, otherwise to PAT_W−1.
- GAP:
  - `signal` = 0, `sig_valid` = 1 for exactly `gap` cycles.
  - Then return to SEND with idx = PAT_W−1.
- DONE:
  - `done` = 1 and `busy` = 0 for one cycle, then IDLE.
  - A start asserted during DONE is ignored.
- start while busy is ignored; latched parameters never change mid-burst.
- Counters:
  - remaining is CNT_W bits wide; reps = 2^CNT_W−1 is legal.
  - The gap counter is GAP_W bits wide.
  - idx is $clog2(PAT_W) bits wide.
  - No counter wraps in legal operation.

## Timing

- Reset: next edge gives state IDLE, and `signal`, `sig_valid`, `pat_end`, `busy`, `done` all 0. A burst in progress is aborted with no `done`.
- Outputs are registered state decodes (Moore), with no combinational path from inputs.
- Latency: start sampled at edge k puts the first bit on `signal` after edge k+1, with `busy` rising at the same time.
- Burst length in cycles, with reps ≥ 1:
  - Non-overlap: reps·PAT_W + (reps−1)·gap.
  - Overlap with gap = 0: PAT_W + (reps−1)·(PAT_W−OVL).
- `done` is high in the cycle immediately after the last bit.
- The next start is accepted in the cycle after `done`.

## Structure

- Shared package `fsm_pkg`:
  - state enum `pg_state_t`;
  - constant function `max_overlap(pat, w)` that computes OVL.
- One natural sub-module, `pattern_serializer`:
  - owns the idx counter, reload-value selection and the PAT[idx] mux;
  - outputs the bit and a `last_bit` flag.
- The top holds the FSM, the remaining and gap counters, and the output registers.

## Test plan

- Default params, reps=1, gap=0 → signal 1,0,1 with sig_valid=1 for 3 cycles. pat_end on the 3rd bit; done in the next cycle; busy high for 3 cycles.
- reps=3, gap=2, overlap=0 → stream 101 00 101 00 101, 13 cycles. pat_end at bits 3, 8 and 13.
- reps=3, gap=0, overlap=1 → stream 1010101, 7 cycles. pat_end at bits 3, 5 and 7. A chained 101 overlapping detector fires 3 times.
- reps=0 with start → no sig_valid; done after 1 cycle.
- Start pulses during a reps=2 burst, and rst asserted at bit 2 of a reps=4 burst → extra starts are ignored. Reset case: all outputs are 0 at the next edge, no done, and a new start behaves normally.
- PAT_W=4, PAT=4'b1101, reps=2, overlap=1 (OVL=1) → stream 1101101, 7 cycles.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types and elaboration helpers for the serial pattern FSM library.
// The generator and its serializer sub-module both import this package.
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } pg_state_t;

  // Returns the length of the longest proper prefix of the w-bit pattern that is also its suffix.
  function automatic int max_overlap(input logic [31:0] pat, input int w);
    int best;
    logic match;
    best = 0;
    for (int k = 1; k < w; k++) begin
      match = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (pat[w - k + j] != pat[j]) match = 1'b0;
      end
      if (match) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/pattern_serializer.sv
// Walks a bit index through PAT from MSB to LSB and presents PAT[idx].
// When a pattern ends, idx restarts at the top or just below the shared overlap.
module pattern_serializer
  import fsm_pkg::*;
#(
  parameter int               PAT_W = 3,
  parameter logic [PAT_W-1:0] PAT   = 3'b101,
  parameter int               OVL   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_step,
  input  logic i_ovl,
  output logic o_bit,
  output logic o_lastBit
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 1 - OVL);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= IDX_TOP;
    end else if (i_load) begin
      r_idx <= IDX_TOP;
    end else if (i_step) begin
      if (r_idx == '0) r_idx <= i_ovl ? IDX_OVL : IDX_TOP;
      else             r_idx <= r_idx - IDX_W'(1);
    end
  end

  assign o_bit     = PAT[r_idx];
  assign o_lastBit = (r_idx == '0);

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern transmitter: sends PAT a latched number of times with optional
// zero gaps or prefix/suffix overlap. All outputs are registered state decodes.
module pattern_gen
  import fsm_pkg::*;
#(
  parameter int               PAT_W = 3,
  parameter logic [PAT_W-1:0] PAT   = 3'b101,
  parameter int               CNT_W = 8,
  parameter int               GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap,
  output logic             signal,
  output logic             sig_valid,
  output logic             pat_end,
  output logic             busy,
  output logic             done
);

  localparam int OVL = max_overlap(32'(PAT), PAT_W);

  pg_state_t        r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [GAP_W-1:0] r_gapLen;
  logic [GAP_W-1:0] r_gapCnt;
  logic             r_ovl;
  logic             r_signal;
  logic             r_sigValid;
  logic             r_patEnd;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_step;
  logic w_bit;
  logic w_lastBit;

  assign w_load = (r_state == ST_IDLE) && start && (reps != '0);
  assign w_step = (r_state == ST_SEND);

  pattern_serializer #(
    .PAT_W (PAT_W),
    .PAT   (PAT),
    .OVL   (OVL)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_ovl     (r_ovl),
    .o_bit     (w_bit),
    .o_lastBit (w_lastBit)
  );

  // Output registers mirror the state being left, so each bit appears one edge after its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_gapLen    <= '0;
      r_gapCnt    <= '0;
      r_ovl       <= 1'b0;
      r_signal    <= 1'b0;
      r_sigValid  <= 1'b0;
      r_patEnd    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_signal   <= (r_state == ST_SEND) && w_bit;
      r_sigValid <= (r_state == ST_SEND) || (r_state == ST_GAP);
      r_patEnd   <= (r_state == ST_SEND) && w_lastBit;
      r_busy     <= (r_state == ST_SEND) || (r_state == ST_GAP);
      r_done     <= (r_state == ST_DONE);

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (reps != '0) begin
              r_remaining <= reps;
              r_gapLen    <= gap;
              // Overlap is meaningless once a gap separates patterns.
              r_ovl       <= overlap && (gap == '0);
              r_state     <= ST_SEND;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_SEND: begin
          if (w_lastBit) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= ST_DONE;
            end else if (r_gapLen != '0) begin
              r_gapCnt <= r_gapLen;
              r_state  <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_gapCnt <= r_gapCnt - GAP_W'(1);
          if (r_gapCnt == GAP_W'(1)) r_state <= ST_SEND;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign signal    = r_signal;
  assign sig_valid = r_sigValid;
  assign pat_end   = r_patEnd;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: default 101 instance plus a 1101 instance,
// checking bit streams, pat_end placement, done/busy timing and reset abort.
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startA = 1'b0;
  logic       startB = 1'b0;
  logic [7:0] reps = '0;
  logic [3:0] gap = '0;
  logic       overlap = 1'b0;

  logic sigA, validA, patEndA, busyA, doneA;
  logic sigB, validB, patEndB, busyB, doneB;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  pattern_gen u_dutA (
    .clk       (clk),
    .rst       (rst),
    .start     (startA),
    .reps      (reps),
    .gap       (gap),
    .overlap   (overlap),
    .signal    (sigA),
    .sig_valid (validA),
    .pat_end   (patEndA),
    .busy      (busyA),
    .done      (doneA)
  );

  pattern_gen #(
    .PAT_W (4),
    .PAT   (4'b1101)
  ) u_dutB (
    .clk       (clk),
    .rst       (rst),
    .start     (startB),
    .reps      (reps),
    .gap       (gap),
    .overlap   (overlap),
    .signal    (sigB),
    .sig_valid (validB),
    .pat_end   (patEndB),
    .busy      (busyB),
    .done      (doneB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sampleOutputs(input int dut, output logic s, output logic v,
                               output logic p, output logic b, output logic d);
    s = (dut == 0) ? sigA    : sigB;
    v = (dut == 0) ? validA  : validB;
    p = (dut == 0) ? patEndA : patEndB;
    b = (dut == 0) ? busyA   : busyB;
    d = (dut == 0) ? doneA   : doneB;
  endtask

  task automatic checkIdle(input int dut, input string tag);
    logic s, v, p, b, d;
    sampleOutputs(dut, s, v, p, b, d);
    checkOutput({tag, " signal"}, s, 0);
    checkOutput({tag, " sig_valid"}, v, 0);
    checkOutput({tag, " pat_end"}, p, 0);
    checkOutput({tag, " busy"}, b, 0);
    checkOutput({tag, " done"}, d, 0);
  endtask

  task automatic applyStimulus(input int dut, input logic [7:0] r, input logic [3:0] g, input logic o);
    reps    = r;
    gap     = g;
    overlap = o;
    if (dut == 0) startA = 1'b1;
    else          startB = 1'b1;
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Starts a burst and checks every transmitted bit, then done and the return to idle.
  task automatic runStream(input string name, input int dut, input logic [7:0] r, input logic [3:0] g,
                           input logic o, input int n, input logic [31:0] bits,
                           input logic [31:0] pe, input bit holdStart);
    logic s, v, p, b, d;
    applyStimulus(dut, r, g, o);
    sampleOutputs(dut, s, v, p, b, d);
    checkOutput($sformatf("%s latency busy", name), b, 0);
    checkOutput($sformatf("%s latency valid", name), v, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      sampleOutputs(dut, s, v, p, b, d);
      checkOutput($sformatf("%s bit%0d signal", name, i + 1), s, bits[n - 1 - i]);
      checkOutput($sformatf("%s bit%0d sig_valid", name, i + 1), v, 1);
      checkOutput($sformatf("%s bit%0d pat_end", name, i + 1), p, pe[n - 1 - i]);
      checkOutput($sformatf("%s bit%0d busy", name, i + 1), b, 1);
      checkOutput($sformatf("%s bit%0d done", name, i + 1), d, 0);
      if (holdStart) begin
        if (dut == 0) startA = 1'b1;
        else          startB = 1'b1;
        reps    = 8'd7;
        gap     = 4'd3;
        overlap = 1'b1;
      end
      tick();
    end
    startA = 1'b0;
    startB = 1'b0;
    sampleOutputs(dut, s, v, p, b, d);
    checkOutput($sformatf("%s done pulse", name), d, 1);
    checkOutput($sformatf("%s done busy", name), b, 0);
    checkOutput($sformatf("%s done sig_valid", name), v, 0);
    checkOutput($sformatf("%s done pat_end", name), p, 0);
    tick();
    checkIdle(dut, $sformatf("%s after done", name));
    tick();
    checkIdle(dut, $sformatf("%s idle again", name));
  endtask

  initial begin
    logic s, v, p, b, d;
    $display("[TB] pattern_gen directed bench");

    rst = 1'b1;
    tick();
    tick();
    checkIdle(0, "reset A");
    checkIdle(1, "reset B");
    rst = 1'b0;
    tick();
    checkIdle(0, "post-reset A");

    // Single 101.
    runStream("r1g0", 0, 8'd1, 4'd0, 1'b0, 3, 32'b101, 32'b001, 1'b0);

    // Three patterns separated by two zero bits.
    runStream("r3g2", 0, 8'd3, 4'd2, 1'b0, 13, 32'b1010010100101, 32'b0010000100001, 1'b0);

    // Three overlapped patterns sharing one bit.
    runStream("r3ov", 0, 8'd3, 4'd0, 1'b1, 7, 32'b1010101, 32'b0010101, 1'b0);

    // Overlap request ignored when a gap is present.
    runStream("r2g1ov", 0, 8'd2, 4'd1, 1'b1, 7, 32'b1010101, 32'b0010001, 1'b0);

    // reps = 0: no bits, done one cycle after the start edge.
    applyStimulus(0, 8'd0, 4'd0, 1'b0);
    checkIdle(0, "r0 after start");
    tick();
    sampleOutputs(0, s, v, p, b, d);
    checkOutput("r0 done", d, 1);
    checkOutput("r0 sig_valid", v, 0);
    checkOutput("r0 busy", b, 0);
    tick();
    checkIdle(0, "r0 idle");

    // Starts and changed inputs during a burst (including its DONE state) are ignored.
    runStream("r2hold", 0, 8'd2, 4'd0, 1'b0, 6, 32'b101101, 32'b001001, 1'b1);

    // Reset during bit 2 of a reps=4 burst aborts without done.
    applyStimulus(0, 8'd4, 4'd0, 1'b0);
    tick();
    sampleOutputs(0, s, v, p, b, d);
    checkOutput("abort bit1 signal", s, 1);
    tick();
    sampleOutputs(0, s, v, p, b, d);
    checkOutput("abort bit2 signal", s, 0);
    checkOutput("abort bit2 busy", b, 1);
    rst = 1'b1;
    tick();
    checkIdle(0, "abort reset edge");
    rst = 1'b0;
    tick();
    checkIdle(0, "abort no done 1");
    tick();
    checkIdle(0, "abort no done 2");
    runStream("post-abort", 0, 8'd1, 4'd0, 1'b0, 3, 32'b101, 32'b001, 1'b0);

    // Four-bit pattern 1101 with OVL = 1.
    runStream("B r2ov", 1, 8'd2, 4'd0, 1'b1, 7, 32'b1101101, 32'b0001001, 1'b0);
    runStream("B r2g0", 1, 8'd2, 4'd0, 1'b0, 8, 32'b11011101, 32'b00010001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
